bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) sitting directly upstream of the 8-digit seven-segment display stage. It takes a binary count from the counter, converts it to eight packed BCD digits, and holds the result stable for the display multiplexer until the next conversion completes. Values beyond the displayable range saturate to all nines, with a flag.

---
 rtl/bin2bcd_seq_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 100 ++++++++++
 tb/tb_bin2bcd_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between the binary counter, the BCD converter
// and the seven-segment display stage.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) ();
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Result and overflow flag are held until the next conversion completes.
module bin2bcd_seq #(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    bin2bcd_seq_if.slave   bus
);
    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [BIN_W-1:0] MAX_DEC  = BIN_W'(10 ** DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic [BIN_W-1:0]    sreg;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_adj;
    logic [ACC_W-1:0]    acc_shift;
    logic                ovf_pend;
    logic [ACC_W-1:0]    bcd_q;
    logic                ovf_q;
    logic                done_q;
    logic                last;

    assign last = (state == SHIFT) && (cnt == CNT_LAST);

    // Add-3 correction on every digit before the shift; a carry out of the
    // top digit only occurs for out-of-range inputs, which are overridden.
    always_comb begin
        acc_adj = acc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        acc_shift = {acc_adj[ACC_W-2:0], sreg[BIN_W-1]};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SHIFT;
            SHIFT:   if (cnt == CNT_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt      <= '0;
            sreg     <= '0;
            acc      <= '0;
            ovf_pend <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    sreg     <= bus.bin;
                    acc      <= '0;
                    cnt      <= '0;
                    ovf_pend <= (bus.bin > MAX_DEC);
                end
            end else begin
                acc  <= acc_shift;
                sreg <= {sreg[BIN_W-2:0], 1'b0};
                cnt  <= cnt + 1'b1;
                if (last) begin
                    cnt    <= '0;
                    bcd_q  <= ovf_pend ? {DIGITS{4'h9}} : acc_shift;
                    ovf_q  <= ovf_pend;
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.busy = (state == SHIFT);
        bus.done = done_q;
        bus.bcd  = bcd_q;
        bus.ovf  = ovf_q;
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: vector table plus multi-cycle corner-case
// sequences (ignored start, back-to-back, asynchronous reset mid-conversion).
module tb_bin2bcd_seq;
    localparam int BIN_W  = 27;
    localparam int DIGITS = 8;

    logic clk;
    logic rst_n;

    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BIN_W-1:0]    bin;
        logic [4*DIGITS-1:0] bcd;
        logic                ovf;
    } vec_t;

    int checks;
    int errors;
    logic [4*DIGITS-1:0] exp_prev;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full conversion: drives start for one edge, then checks latency,
    // busy length, held result during the conversion, result and done width.
    task automatic run_conv(input logic [BIN_W-1:0] b, input logic [4*DIGITS-1:0] e_bcd,
                            input logic e_ovf);
        int cycles;
        int busy_cnt;
        bus.start = 1'b1;
        bus.bin   = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.bin   = '0;
        cycles   = 0;
        busy_cnt = bus.busy ? 1 : 0;
        while (!bus.done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.busy) busy_cnt++;
            if (cycles == 13) chk("bcd_held_mid", bus.bcd, exp_prev);
        end
        chk("latency", cycles, BIN_W);
        chk("busy_len", busy_cnt, BIN_W);
        chk("bcd", bus.bcd, e_bcd);
        chk("ovf", bus.ovf, e_ovf);
        @(posedge clk);
        #1;
        chk("done_width", bus.done, 1'b0);
        chk("bcd_hold", bus.bcd, e_bcd);
        exp_prev = e_bcd;
    endtask

    task automatic count_dones(input int n, output int dones);
        dones = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
    endtask

    vec_t vecs[10];

    initial begin
        int cycles;
        int gap;
        int dones;

        checks = 0;
        errors = 0;
        exp_prev = '0;
        vecs[0] = '{27'd0,         32'h00000000, 1'b0};
        vecs[1] = '{27'd12345678,  32'h12345678, 1'b0};
        vecs[2] = '{27'd99999999,  32'h99999999, 1'b0};
        vecs[3] = '{27'd100000000, 32'h99999999, 1'b1};
        vecs[4] = '{27'h7FFFFFF,   32'h99999999, 1'b1};
        vecs[5] = '{27'd10,        32'h00000010, 1'b0};
        vecs[6] = '{27'd99,        32'h00000099, 1'b0};
        vecs[7] = '{27'd1000000,   32'h01000000, 1'b0};
        vecs[8] = '{27'd9999,      32'h00009999, 1'b0};
        vecs[9] = '{27'd1,         32'h00000001, 1'b0};

        bus.start = 1'b0;
        bus.bin   = '0;
        rst_n     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_bcd", bus.bcd, 32'h0);
        chk("rst_ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++)
            run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);

        // start pulsed mid-conversion must be ignored
        bus.start = 1'b1;
        bus.bin   = 27'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.bin   = '0;
        cycles = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.start = 1'b1;
        bus.bin   = 27'd42;
        @(posedge clk);
        #1;
        cycles++;
        bus.start = 1'b0;
        bus.bin   = '0;
        while (!bus.done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("ign_latency", cycles, BIN_W);
        chk("ign_bcd", bus.bcd, 32'h00000005);
        count_dones(40, dones);
        chk("ign_no_second_done", dones, 0);

        // start held high: accepted again in the done cycle
        bus.start = 1'b1;
        bus.bin   = 27'd7;
        @(posedge clk);
        #1;
        cycles = 0;
        while (!bus.done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("b2b_first_latency", cycles, BIN_W);
        chk("b2b_first_bcd", bus.bcd, 32'h00000007);
        bus.bin = 27'd9;
        gap = 0;
        do begin
            @(posedge clk);
            #1;
            gap++;
            if (gap == 1) begin
                chk("b2b_busy_after_done", bus.busy, 1'b1);
                bus.start = 1'b0;
                bus.bin   = '0;
            end
        end while (!bus.done && gap < 100);
        chk("b2b_spacing", gap, BIN_W + 1);
        chk("b2b_second_bcd", bus.bcd, 32'h00000009);
        count_dones(40, dones);

        // asynchronous reset in the middle of a conversion
        exp_prev = 32'h00000009;
        run_conv(27'd12345678, 32'h12345678, 1'b0);
        bus.start = 1'b1;
        bus.bin   = 27'd87654321;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.bin   = '0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_bcd", bus.bcd, 32'h0);
        chk("arst_ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(40, dones);
        chk("arst_no_stray_done", dones, 0);
        exp_prev = '0;
        run_conv(27'd87654321, 32'h87654321, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
